vector_op_sequencer: RTL

Command/operand front end for `vector_element_alu`. It receives a word stream from the host link, unpacks the header, length, A elements and either B elements or one scalar into the ALU operand registers, and fires one ALU operation. It then captures the `S` result vector and streams the valid elements back out. It sits between the host-facing stream interface and the element ALU, and is the only driver of the ALU's `A`, `B`, `scalar`, `op_sel`, `scalar_sel`, `set` and `en` inputs.

---
 rtl/vec_pkg.sv | 24 ++
 rtl/vector_op_sequencer_if.sv | 24 ++
 rtl/vseq_out_buf.sv | 76 +++++++
 rtl/vector_op_sequencer.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared types and header field layout for the vector op sequencer.
// Imported by the sequencer top and its output buffer.
package vec_pkg;

  typedef enum logic [2:0] {
    S_HDR,
    S_LEN,
    S_LOAD_A,
    S_LOAD_B,
    S_LOAD_S,
    S_FIRE,
    S_WAIT,
    S_SEND
  } vseq_state_t;

  localparam int HDR_OP_LSB     = 0;
  localparam int HDR_OP_W       = 3;
  localparam int HDR_SCALAR_BIT = 3;

  function automatic int LEN_W(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/vector_op_sequencer_if.sv
// Host-facing word streams: inbound operands, outbound results.
// master = host side, slave = sequencer side.
interface vector_op_sequencer_if #(
  parameter int BITS = 8
);

  logic [BITS-1:0] in_data;
  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] out_data;
  logic            out_valid;
  logic            out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/vseq_out_buf.sv
// Result capture register plus valid/ready output slice.
// VEC_SEQ_STATUS_EN appends a status word after the results.
module vseq_out_buf #(
  parameter int BITS = 8,
  parameter int N    = 4,
  parameter int LW   = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   capture,
  input  logic [N-1:0][BITS-1:0] s,
  input  logic [LW-1:0]          len,
`ifdef VEC_SEQ_STATUS_EN
  input  logic [3:0]             tag,
`endif
  input  logic                   out_ready,
  output logic [BITS-1:0]        out_data,
  output logic                   out_valid,
  output logic                   done
);

  logic [N-1:0][BITS-1:0] res;
  logic [LW-1:0]          idx;
  logic [LW-1:0]          nxt;
  logic [LW-1:0]          final_idx;
  logic [BITS-1:0]        word;

`ifdef VEC_SEQ_STATUS_EN
  logic [3:0]      ops;
  logic [BITS-1:0] status;

  assign final_idx = len;
  assign status    = BITS'({ops, tag});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ops <= '0;
    else if (done) ops <= ops + 4'd1;
  end
`else
  assign final_idx = len - LW'(1);
`endif

  assign done = out_valid && out_ready && (idx == final_idx);

  always_comb begin
    nxt  = idx + LW'(1);
    word = '0;
    for (int i = 0; i < N; i++)
      if (LW'(i) == nxt) word = res[i];
`ifdef VEC_SEQ_STATUS_EN
    if (nxt == len) word = status;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res       <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (capture) begin
      res       <= s;
      idx       <= '0;
      out_valid <= 1'b1;
      out_data  <= s[0];
    end else if (out_valid && out_ready) begin
      if (idx == final_idx) begin
        out_valid <= 1'b0;
      end else begin
        idx      <= nxt;
        out_data <= word;
      end
    end
  end

endmodule

// File: rtl/vector_op_sequencer.sv
// Unpacks host frames into ALU operands, fires one op, streams S back.
// Optional status word: define VEC_SEQ_STATUS_EN.
module vector_op_sequencer
  import vec_pkg::*;
#(
  parameter int BITS    = 8,
  parameter int N       = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  vector_op_sequencer_if.slave    host,
  output logic [N-1:0][BITS-1:0]  A,
  output logic [N-1:0][BITS-1:0]  B,
  output logic [LEN_W(N)-1:0]     A_len,
  output logic [LEN_W(N)-1:0]     B_len,
  output logic [BITS-1:0]         scalar,
  output logic [2:0]              op_sel,
  output logic                    scalar_sel,
  output logic                    set,
  output logic                    en,
  input  logic [N-1:0][BITS-1:0]  S
);

  localparam int LW = LEN_W(N);

  vseq_state_t   state, nstate;
  logic [LW-1:0] len, idx, len_in;
  logic [3:0]    wcnt;
  logic          rdy, xfer, capture, done, lane_last;

  assign host.in_ready = rdy;
  assign xfer      = host.in_valid && rdy;
  assign lane_last = (idx == len - LW'(1));
  assign len_in    = (host.in_data > BITS'(N)) ? LW'(N) : host.in_data[LW-1:0];
  assign A_len     = len;
  assign B_len     = len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_HDR;
    else     state <= nstate;
  end

  always_comb begin
    nstate  = state;
    rdy     = 1'b0;
    set     = 1'b0;
    capture = 1'b0;
    unique case (state)
      S_HDR: begin
        rdy = 1'b1;
        if (host.in_valid) nstate = S_LEN;
      end
      S_LEN: begin
        rdy = 1'b1;
        if (host.in_valid)
          nstate = (host.in_data == '0) ? S_HDR : S_LOAD_A;
      end
      S_LOAD_A: begin
        rdy = 1'b1;
        if (host.in_valid && lane_last)
          nstate = scalar_sel ? S_LOAD_S : S_LOAD_B;
      end
      S_LOAD_B: begin
        rdy = 1'b1;
        if (host.in_valid && lane_last) nstate = S_FIRE;
      end
      S_LOAD_S: begin
        rdy = 1'b1;
        if (host.in_valid) nstate = S_FIRE;
      end
      S_FIRE: begin
        set = 1'b1;
        // Zero-latency ALU: S is already valid alongside set
        if (ALU_LAT == 0) begin
          capture = 1'b1;
          nstate  = S_SEND;
        end else begin
          nstate = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wcnt == 4'(ALU_LAT - 1)) begin
          capture = 1'b1;
          nstate  = S_SEND;
        end
      end
      S_SEND: begin
        if (done) nstate = S_HDR;
      end
      default: nstate = S_HDR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      A          <= '0;
      B          <= '0;
      scalar     <= '0;
      op_sel     <= '0;
      scalar_sel <= 1'b0;
      en         <= 1'b0;
      len        <= '0;
      idx        <= '0;
      wcnt       <= '0;
    end else begin
      wcnt <= (state == S_WAIT) ? wcnt + 4'd1 : 4'd0;
      if (state == S_HDR && xfer) begin
        op_sel     <= host.in_data[HDR_OP_LSB +: HDR_OP_W];
        scalar_sel <= host.in_data[HDR_SCALAR_BIT];
        A          <= '0;
        B          <= '0;
      end
      if (state == S_LEN && xfer) begin
        len <= len_in;
        idx <= '0;
        en  <= (host.in_data != '0);
      end
      if ((state == S_LOAD_A || state == S_LOAD_B) && xfer) begin
        for (int i = 0; i < N; i++)
          if (LW'(i) == idx) begin
            if (state == S_LOAD_A) A[i] <= host.in_data;
            else                   B[i] <= host.in_data;
          end
        idx <= lane_last ? '0 : idx + LW'(1);
      end
      if (state == S_LOAD_S && xfer) scalar <= host.in_data;
      if (done) en <= 1'b0;
    end
  end

  vseq_out_buf #(
    .BITS (BITS),
    .N    (N),
    .LW   (LW)
  ) u_out (
    .clk       (clk),
    .rst       (rst),
    .capture   (capture),
    .s         (S),
    .len       (len),
`ifdef VEC_SEQ_STATUS_EN
    .tag       ({scalar_sel, op_sel}),
`endif
    .out_ready (host.out_ready),
    .out_data  (host.out_data),
    .out_valid (host.out_valid),
    .done      (done)
  );

endmodule
